// File: rtl/crc_stream_engine.sv
// Streaming CRC: one beat per cycle, unrolled bitwise LFSR; result valid the cycle after the last beat.
// Backpressure: s_ready drops while a result is held; crc_ready releases it and re-arms the register.
module crc_stream_engine #(
   parameter int               DATA_W  = 32,
   parameter int               CRC_W   = 32,
   parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
   parameter logic [CRC_W-1:0] INIT    = 32'hFFFFFFFF,
   parameter bit               REFIN   = 1'b1,
   parameter bit               REFOUT  = 1'b1,
   parameter logic [CRC_W-1:0] XOROUT  = 32'hFFFFFFFF,
   parameter logic [CRC_W-1:0] RESIDUE = 32'hC704DD7B,
   parameter int               LEN_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic                s_last,
   input  logic                mode_check,
   output logic                crc_valid,
   input  logic                crc_ready,
   output logic [CRC_W-1:0]    crc_out,
   output logic                crc_ok,
   output logic [LEN_W-1:0]    byte_cnt
);

   localparam int NB = DATA_W / 8;

   typedef enum logic {RUN, HOLD} state_t;

   typedef struct packed {
      logic [CRC_W-1:0] crc;
      logic             ok;
      logic [LEN_W-1:0] cnt;
   } result_t;

   state_t           state;
   result_t          res;
   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] crc_nxt;
   logic [LEN_W-1:0] cnt_reg;
   logic [LEN_W-1:0] cnt_nxt;
   logic [NB-1:0]    keep_eff;
   logic             accept;

   function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      r = '0;
      for (int k = 0; k < CRC_W; k++) r[k] = v[CRC_W-1-k];
      return r;
   endfunction

   assign accept   = s_valid && s_ready;
   assign keep_eff = s_last ? s_keep : '1;

   // Kept bytes are contiguous from byte 0, so per-byte gating preserves wire order.
   always_comb begin : crc_unroll
      logic [CRC_W-1:0] r;
      logic             b;
      logic             fb;
      r  = crc_reg;
      b  = 1'b0;
      fb = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (keep_eff[i]) begin
            for (int j = 0; j < 8; j++) begin
               b  = REFIN ? s_data[8*i+j] : s_data[8*i+7-j];
               fb = r[CRC_W-1] ^ b;
               r  = (r << 1) ^ (fb ? POLY : '0);
            end
         end
      end
      crc_nxt = r;
   end

   always_comb begin : cnt_add
      logic [LEN_W:0] sum;
      sum = {1'b0, cnt_reg};
      for (int i = 0; i < NB; i++) sum = sum + {{LEN_W{1'b0}}, keep_eff[i]};
      cnt_nxt = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         crc_reg   <= INIT;
         cnt_reg   <= '0;
         s_ready   <= 1'b1;
         crc_valid <= 1'b0;
         res       <= '0;
      end else begin
         case (state)
            RUN: begin
               if (accept) begin
                  crc_reg <= crc_nxt;
                  cnt_reg <= cnt_nxt;
                  if (s_last) begin
                     res.crc   <= (REFOUT ? bitrev(crc_nxt) : crc_nxt) ^ XOROUT;
                     res.ok    <= mode_check && (crc_nxt == RESIDUE);
                     res.cnt   <= cnt_nxt;
                     state     <= HOLD;
                     s_ready   <= 1'b0;
                     crc_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (crc_ready) begin
                  state     <= RUN;
                  crc_reg   <= INIT;
                  cnt_reg   <= '0;
                  s_ready   <= 1'b1;
                  crc_valid <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign crc_out  = res.crc;
   assign crc_ok   = res.ok;
   assign byte_cnt = res.cnt;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Randomized and directed frames against a reflected table-free CRC-32 reference.
module tb_crc_stream_engine;

   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_data;
   logic [3:0]    s_keep;
   logic          s_last;
   logic          mode_check;
   logic          crc_valid;
   logic          crc_ready;
   logic [31:0]   crc_out;
   logic          crc_ok;
   logic [LW-1:0] byte_cnt;

   typedef logic [7:0] bq_t[$];

   int n_chk = 0;
   int n_err = 0;

   crc_stream_engine #(.DATA_W(32), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .mode_check(mode_check), .crc_valid(crc_valid),
      .crc_ready(crc_ready), .crc_out(crc_out), .crc_ok(crc_ok), .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Standard reflected CRC-32 on a byte list.
   function automatic logic [31:0] ref_crc(input bq_t d);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'h0, d[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // A frame is good when its last four bytes are the little-endian CRC of the rest.
   function automatic logic ref_ok(input bq_t d);
      bq_t         body;
      int          n;
      logic [31:0] tail;
      n = d.size();
      if (n < 4) return 1'b0;
      for (int i = 0; i < n - 4; i++) body.push_back(d[i]);
      tail = {d[n-1], d[n-2], d[n-3], d[n-4]};
      return ref_crc(body) == tail;
   endfunction

   task automatic run_frame(input string tag, input bq_t d, input logic mode,
                            input int hold, input int bub_pct);
      int          n;
      int          nb;
      int          to;
      int          idx;
      int          rem;
      logic [31:0] e_crc;
      logic        e_ok;
      logic [LW-1:0] e_cnt;
      n     = d.size();
      nb    = (n == 0) ? 1 : (n + 3) / 4;
      e_crc = ref_crc(d);
      e_ok  = mode && ref_ok(d);
      e_cnt = (n > 255) ? 8'hFF : LW'(n);
      for (int k = 0; k < nb; k++) begin
         if (bub_pct > 0 && $urandom_range(99) < bub_pct) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            tick;
         end
         to = 0;
         while (!s_ready && to < 20) begin
            tick;
            to++;
         end
         if (!s_ready) chk({tag, "_ready_timeout"}, 64'(s_ready), 64'd1);
         s_valid = 1'b1;
         s_last  = (k == nb - 1);
         for (int i = 0; i < 4; i++) begin
            idx = 4 * k + i;
            s_data[8*i +: 8] = (idx < n) ? d[idx] : 8'($urandom);
         end
         rem        = n - 4 * k;
         s_keep     = s_last ? 4'((1 << rem) - 1) : 4'($urandom);
         mode_check = s_last ? mode : 1'($urandom);
         tick;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk({tag, "_valid"}, 64'(crc_valid), 64'd1);
      chk({tag, "_crc"}, 64'(crc_out), 64'(e_crc));
      chk({tag, "_cnt"}, 64'(byte_cnt), 64'(e_cnt));
      chk({tag, "_ok"}, 64'(crc_ok), 64'(e_ok));
      for (int h = 0; h < hold; h++) begin
         s_valid = 1'b1;
         s_data  = $urandom;
         s_keep  = 4'($urandom);
         s_last  = 1'($urandom);
         tick;
         chk({tag, "_hold_valid"}, 64'(crc_valid), 64'd1);
         chk({tag, "_hold_ready"}, 64'(s_ready), 64'd0);
         chk({tag, "_hold_crc"}, {crc_out, 24'h0, byte_cnt}, {e_crc, 24'h0, e_cnt});
      end
      s_valid   = 1'b0;
      s_last    = 1'b0;
      crc_ready = 1'b1;
      tick;
      crc_ready = 1'b0;
      chk({tag, "_drop_valid"}, 64'(crc_valid), 64'd0);
      chk({tag, "_rearm_ready"}, 64'(s_ready), 64'd1);
   endtask

   bq_t std9;
   bq_t q;
   bq_t body;
   logic [31:0] c;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
      mode_check = 1'b0; crc_ready = 1'b0;
      for (int i = 0; i < 9; i++) std9.push_back(8'h31 + 8'(i));
      tick;
      tick;
      chk("rst_ready", 64'(s_ready), 64'd1);
      chk("rst_valid", 64'(crc_valid), 64'd0);
      chk("rst_outs", {crc_out, 23'h0, crc_ok, byte_cnt}, 64'd0);
      rst = 1'b0;

      run_frame("std", std9, 1'b0, 0, 0);
      chk("std_const", 64'(crc_out), 64'hCBF43926);

      q = std9;
      q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
      run_frame("chk_good", q, 1'b1, 0, 0);
      chk("chk_const", {crc_out, 31'h0, crc_ok}, {32'h2144DF1C, 32'h1});
      q[3] = q[3] ^ 8'h10;
      run_frame("chk_bad", q, 1'b1, 0, 0);

      q.delete();
      run_frame("empty", q, 1'b0, 0, 0);

      run_frame("bp", std9, 1'b0, 5, 0);
      run_frame("b2b", std9, 1'b0, 0, 0);

      // Reset with two beats of a frame already absorbed.
      s_valid = 1'b1; s_last = 1'b0; s_keep = 4'hF; s_data = 32'h34333231;
      tick;
      s_data = 32'h38373635;
      tick;
      s_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_valid", 64'(crc_valid), 64'd0);
      chk("midrst_ready", 64'(s_ready), 64'd1);
      run_frame("after_rst", std9, 1'b0, 0, 0);

      // Reset while a result is held.
      s_valid = 1'b1; s_last = 1'b1; s_keep = 4'h3; s_data = $urandom;
      tick;
      s_valid = 1'b0; s_last = 1'b0;
      chk("hold_rst_pre", 64'(crc_valid), 64'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("hold_rst_valid", 64'(crc_valid), 64'd0);
      chk("hold_rst_outs", {crc_out, 23'h0, crc_ok, byte_cnt}, 64'd0);
      chk("hold_rst_ready", 64'(s_ready), 64'd1);

      q.delete();
      for (int i = 0; i < 300; i++) q.push_back(8'($urandom));
      run_frame("sat", q, 1'b0, 1, 10);

      for (int f = 0; f < 40; f++) begin
         q.delete();
         for (int i = 0; i < $urandom_range(24); i++) q.push_back(8'($urandom));
         if (q.size() >= 4 && $urandom_range(1) == 1) begin
            body.delete();
            for (int i = 0; i < q.size() - 4; i++) body.push_back(q[i]);
            c = ref_crc(body);
            for (int i = 0; i < 4; i++) q[q.size() - 4 + i] = c[8*i +: 8];
         end
         run_frame($sformatf("rnd%0d", f), q, 1'($urandom), $urandom_range(3), 30);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
Parametrised streaming CRC engine that generalises the team's fixed 8-bit CRC-32 LFSR. It supports any byte-multiple data width, a configurable polynomial, init value, reflection and final XOR, and per-byte keep on the last beat. It frames data with a valid/ready/last handshake, counts frame bytes, and provides a check mode that validates a received trailing CRC against the residue. It sits between the SRAM controller data path and the frame/packet logic.

Parameters:
DATA_W, 32, input beat width in bits; must be a multiple of 8, range 8..64
CRC_W, 32, CRC register width
POLY, 32'h04C11DB7, generator polynomial in normal (non-reflected) form, x^CRC_W term implicit
INIT, 32'hFFFFFFFF, register value at frame start
REFIN, 1, 1 = bits of each byte fed LSB first; 0 = MSB first
REFOUT, 1, 1 = bit-reverse the register before the final XOR
XOROUT, 32'hFFFFFFFF, final XOR applied to crc_out
RESIDUE, 32'hC704DD7B, raw register value that indicates a good frame in check mode
LEN_W, 16, width of the byte counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input beat valid
s_ready  out  1  engine accepts a beat
s_data  in  DATA_W  beat data; byte 0 = s_data[7:0] is first on the wire
s_keep  in  DATA_W/8  byte enables, honoured on the last beat only
s_last  in  1  final beat of the frame
mode_check  in  1  1 = frame includes the trailing received CRC; sampled on the accepted last beat
crc_valid  out  1  result valid
crc_ready  in  1  downstream accepts the result
crc_out  out  CRC_W  final CRC = (REFOUT ? bitrev(reg) : reg) ^ XOROUT
crc_ok  out  1  check mode: raw reg == RESIDUE; forced 0 in generate mode
byte_cnt  out  LEN_W  bytes processed in the frame, saturating at all-ones

Behaviour:
- Reset: state = RUN, reg = INIT, byte counter = 0, s_ready = 1, crc_valid = 0, crc_out = 0, crc_ok = 0, byte_cnt = 0. Reset overrides everything, including an in-progress frame or a held result.
- Register is held in normal form: bit CRC_W-1 is the x^(CRC_W-1) coefficient.
- Per accepted beat, the bytes are processed in order 0..N-1. Each bit step is: fb = reg[MSB] ^ bit; reg = (reg << 1) ^ (fb ? POLY : 0). This is fully combinational and unrolled across the beat, one beat per cycle, with no bubbles.
- A beat is accepted when s_valid && s_ready.
- Non-last beats: all bytes are processed and s_keep is ignored.
- Last beat: only bytes with s_keep[i] = 1 are processed. The keep pattern must be contiguous from byte 0; non-contiguous keep is unsupported, and the engine processes set bits in index order. keep = 0 processes no bytes and still closes the frame.
- byte_cnt adds popcount(effective keep) per beat and saturates at 2^LEN_W-1.
- State machine:
  - RUN: s_ready = 1. On an accepted last beat: latch crc_out, crc_ok and byte_cnt from the post-beat register and count, then go to HOLD.
  - HOLD: s_ready = 0, crc_valid = 1, outputs stable. On crc_ready = 1: go to RUN, set reg = INIT, clear the counter, drop crc_valid the next cycle. s_ready returns to 1 in that same next cycle.
- Latency: crc_valid rises in the cycle after the last beat is accepted. Minimum frame-to-frame gap is 1 cycle of s_ready = 0, the HOLD cycle with crc_ready = 1.
- The first beat of the next frame cannot be accepted in the cycle the result is consumed.
- Generate mode (mode_check = 0): crc_ok = 0.
- Check mode (mode_check = 1): the trailing CRC bytes are part of the data, and crc_ok = (raw reg == RESIDUE).
- Outputs retain their last latched values while in RUN; crc_valid = 0 qualifies them.
- s_valid during HOLD is ignored and no beat is consumed.

Test Plan:
- DATA_W=8, defaults: bytes "123456789" (0x31..0x39), last on 0x39 -> crc_valid the next cycle, crc_out = 0xCBF43926, byte_cnt = 9, crc_ok = 0.
- DATA_W=32: beats 0x34333231, 0x38373635, then last 0x00000039 with keep 4'b0001 -> crc_out = 0xCBF43926, byte_cnt = 9, zero bubbles between beats.
- Check mode, DATA_W=32: "123456789" followed by bytes 26 39 F4 CB (beats 0x34333231, 0x38373635, 0xF4392639, last 0x000000CB keep 4'b0001) -> crc_ok = 1, crc_out = 0x2144DF1C, byte_cnt = 13. Flip one data bit -> crc_ok = 0.
- Empty frame: single beat with last = 1, keep = 0 -> crc_out = 0x00000000, byte_cnt = 0.
- Backpressure: hold crc_ready = 0 for 5 cycles after the result -> crc_valid, crc_out and byte_cnt stay stable, s_ready = 0, s_valid beats are not consumed. Raise crc_ready -> a back-to-back second "123456789" frame again yields 0xCBF43926.
- Reset mid-frame: after 5 bytes, pulse rst for 1 cycle -> crc_valid = 0, s_ready = 1. A fresh "123456789" frame yields 0xCBF43926 with byte_cnt = 9.
